hack_cpu_core: RTL and testbench
================================

Name: hack_cpu_core

Overview:
Control and register stage wrapped around the 16-bit Hack ALU. It decodes Hack A/C instructions and holds the A, D and PC registers. It drives the ALU's x/y operands and its 6-bit control, then consumes the ALU's out/zr/ng to write back registers, memory and the jump decision. It targets synchronous ROM/RAM, so every instruction takes two cycles: FETCH then EXECUTE.

Parameters:
PC_WIDTH, 15, program counter and ROM address width
DATA_WIDTH, 16, data path width; only 16 is supported

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
hold  input  1  freezes all state while high
rom_addr  output  15  instruction address (= PC)
rom_data  input  16  instruction word, valid the cycle after rom_addr is presented
inM  input  16  RAM read data at addressM, valid the cycle after addressM is presented
addressM  output  15  RAM address (= A[14:0])
outM  output  16  RAM write data (= alu_out)
writeM  output  1  RAM write enable
alu_x  output  16  ALU x operand (= D)
alu_y  output  16  ALU y operand (A or inM)
alu_control  output  6  {zx,nx,zy,ny,f,no}
alu_out  input  16  ALU result (combinational)
alu_zr  input  1  ALU result == 0
alu_ng  input  1  ALU result bit 15
pc  output  15  current PC, for debug
state_exec  output  1  1 when in EXECUTE, for debug

Behaviour:
- Reset (clk edge with reset=1): PC=0, A=0, D=0, IR=0, state=FETCH. After reset, writeM=0.
- reset has priority over hold.
- hold=1: no register changes and state is frozen. writeM is forced to 0 while hold=1.
- FETCH state:
  - rom_addr=PC.
  - On the edge: IR<=rom_data; state<=EXECUTE.
  - No A/D/PC change; writeM=0.
- EXECUTE state (IR decoded combinationally; ALU is in the combinational path):
  - A-instruction (IR[15]=0):
    - A<=IR (bit 15 is 0).
    - D unchanged, no memory write.
    - PC<=PC+1.
  - C-instruction (IR[15]=1):
    - IR[14:13] are ignored.
    - a=IR[12]: alu_y = a ? inM : A.
    - alu_x=D; alu_control=IR[11:6].
    - Destinations: IR[5]: A<=alu_out. IR[4]: D<=alu_out. IR[3]: writeM=1 this cycle, with outM=alu_out and addressM=old A.
  - All destination writes use the pre-edge A/D values as operands, so simultaneous A and D writes are consistent.
  - Jump: jmp = (IR[2]&alu_ng) | (IR[1]&alu_zr) | (IR[0]&~alu_ng&~alu_zr).
    - PC <= jmp ? old A[14:0] : PC+1.
    - The target is the A value before any same-instruction A write.
  - state<=FETCH.
- alu_control and alu_y are don't-care outside EXECUTE or for A-instructions. Drive them from IR regardless.
- inM validity: A is stable through FETCH, so inM is valid in EXECUTE.
- PC increment wraps 0x7FFF -> 0x0000 (15-bit modulo).
- Outputs outside EXECUTE:
  - writeM=0.
  - addressM=A[14:0] at all times.
  - outM=alu_out at all times; it is only meaningful when writeM=1.
- Reset asserted mid-instruction (in EXECUTE): the pending write is suppressed, writeM=0 in that cycle, and the next state is FETCH at PC=0.
- Throughput: one instruction per 2 unheld cycles.

Test Plan:
- Reset, then ROM[0]=0x0005 (@5) -> after 2 cycles A=5, PC=1, writeM never asserted.
- @5, then ROM[1]=0xEC10 (D=A) -> alu_control=6'b110000, alu_y=5; D=5 after EXECUTE; PC=2.
- A=100, D=7, instr 0xE308 (M=D) -> in EXECUTE writeM=1, addressM=100, outM=7; next cycle writeM=0.
- A=20, D=0, instr 0xE302 (D;JEQ) with alu_zr=1 -> PC=20. Repeat with D=1 -> PC=old+1. Check 0xE301 (JGT) with alu_ng=1 -> no jump.
- A=30, instr 0xEDE7 (A=A+1;JMP) -> A=31, PC=30 (old A).
- PC=0x7FFF executing @0 -> PC wraps to 0. hold=1 for 3 cycles mid-EXECUTE -> no state change, writeM=0; resumes identically. Reset during EXECUTE of M=D -> writeM stays 0, PC=0.

Source files
------------

// File: rtl/hack_cpu_core.sv
// Hack CPU control/register stage: decodes A/C instructions, owns A, D, PC and IR,
// and drives an external combinational Hack ALU. Each instruction is FETCH then EXECUTE.
module hack_cpu_core #(
    parameter int PC_WIDTH   = 15,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    output logic [PC_WIDTH-1:0]   rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic [DATA_WIDTH-1:0] inM,
    output logic [PC_WIDTH-1:0]   addressM,
    output logic [DATA_WIDTH-1:0] outM,
    output logic                  writeM,
    output logic [DATA_WIDTH-1:0] alu_x,
    output logic [DATA_WIDTH-1:0] alu_y,
    output logic [5:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_zr,
    input  logic                  alu_ng,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  state_exec
);

    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] ir_reg;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] d_reg;
    logic [PC_WIDTH-1:0]   pc_reg;

    logic                  is_c;
    logic                  jmp;
    logic [PC_WIDTH-1:0]   pc_next;
    logic                  unused_bits;

    // IR[14:13] carry no meaning in the Hack encoding.
    assign unused_bits = ^ir_reg[14:13];

    assign is_c        = ir_reg[15];
    assign alu_x       = d_reg;
    assign alu_y       = ir_reg[12] ? inM : a_reg;
    assign alu_control = ir_reg[11:6];
    assign rom_addr    = pc_reg;
    assign addressM    = a_reg[PC_WIDTH-1:0];
    assign outM        = alu_out;
    assign pc          = pc_reg;
    assign state_exec  = (state == EXECUTE);

    // writeM is combinational so the store lands in the same EXECUTE cycle;
    // hold and reset both suppress it so a frozen or aborted instruction never writes.
    assign writeM = (state == EXECUTE) && is_c && ir_reg[3] && !hold && !reset;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        jmp        = 1'b0;
        pc_next    = pc_reg + PC_WIDTH'(1);
        case (state)
            FETCH: begin
                state_next = EXECUTE;
            end
            EXECUTE: begin
                state_next = FETCH;
                if (is_c) begin
                    jmp = (ir_reg[2] & alu_ng) | (ir_reg[1] & alu_zr) |
                          (ir_reg[0] & ~alu_ng & ~alu_zr);
                end
                if (jmp) begin
                    pc_next = a_reg[PC_WIDTH-1:0];
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // NOTE: non-blocking assignments make every right-hand side the pre-edge value,
    // which is what lets A be both jump target and destination in one instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            ir_reg <= '0;
            a_reg  <= '0;
            d_reg  <= '0;
            pc_reg <= '0;
        end else if (!hold) begin
            state <= state_next;
            if (state == FETCH) begin
                ir_reg <= rom_data;
            end else begin
                pc_reg <= pc_next;
                if (!is_c) begin
                    a_reg <= ir_reg;
                end else begin
                    if (ir_reg[5]) a_reg <= alu_out;
                    if (ir_reg[4]) d_reg <= alu_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_hack_cpu_core.sv
// Directed bench for hack_cpu_core with a behavioural Hack ALU in the loop;
// instructions are fed one at a time through rom_data.
module tb_hack_cpu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] inM;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_control;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [14:0] pc;
    logic        state_exec;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;

    hack_cpu_core dut (
        .clk(clk), .reset(reset), .hold(hold),
        .rom_addr(rom_addr), .rom_data(rom_data), .inM(inM),
        .addressM(addressM), .outM(outM), .writeM(writeM),
        .alu_x(alu_x), .alu_y(alu_y), .alu_control(alu_control),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc(pc), .state_exec(state_exec)
    );

    always #5 clk = ~clk;

    // Reference Hack ALU: {zx,nx,zy,ny,f,no}.
    always_comb begin
        logic [15:0] x1, y1, o;
        x1 = alu_control[5] ? 16'h0000 : alu_x;
        x1 = alu_control[4] ? ~x1 : x1;
        y1 = alu_control[3] ? 16'h0000 : alu_y;
        y1 = alu_control[2] ? ~y1 : y1;
        o  = alu_control[1] ? (x1 + y1) : (x1 & y1);
        o  = alu_control[0] ? ~o : o;
        alu_out = o;
        alu_zr  = (o == 16'h0000);
        alu_ng  = o[15];
    end

    always @(posedge clk) if (writeM) wr_cnt <= wr_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Called in FETCH: present the instruction and advance into EXECUTE.
    task automatic fetch(input logic [15:0] instr);
        check("fetch_state", {31'b0, state_exec}, 32'd0);
        check("fetch_wr", {31'b0, writeM}, 32'd0);
        rom_data = instr;
        tick();
    endtask

    task automatic run(input logic [15:0] instr);
        fetch(instr);
        tick();
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; rom_data = 16'h0000; inM = 16'h0000;
        tick(); tick();
        check("rst_pc", {17'b0, pc}, 32'd0);
        check("rst_a", {17'b0, addressM}, 32'd0);
        check("rst_d", {16'b0, alu_x}, 32'd0);
        check("rst_state", {31'b0, state_exec}, 32'd0);
        check("rst_wr", {31'b0, writeM}, 32'd0);
        reset = 1'b0;
        #1;

        // @5
        run(16'h0005);
        check("a5", {17'b0, addressM}, 32'd5);
        check("a5_pc", {17'b0, pc}, 32'd1);

        // D=A
        fetch(16'hEC10);
        check("dA_ctl", {26'b0, alu_control}, 32'h30);
        check("dA_y", {16'b0, alu_y}, 32'd5);
        tick();
        check("dA_d", {16'b0, alu_x}, 32'd5);
        check("dA_pc", {17'b0, pc}, 32'd2);
        check("no_wr_yet", wr_cnt, 32'd0);

        // D=7, A=100, M=D
        run(16'h0007);
        run(16'hEC10);
        run(16'h0064);
        fetch(16'hE308);
        check("md_wr", {31'b0, writeM}, 32'd1);
        check("md_addr", {17'b0, addressM}, 32'd100);
        check("md_out", {16'b0, outM}, 32'd7);
        tick();
        check("md_wr_off", {31'b0, writeM}, 32'd0);
        check("md_pc", {17'b0, pc}, 32'd6);

        // D=0, A=20, D;JEQ taken
        run(16'hEA90);
        run(16'h0014);
        run(16'hE302);
        check("jeq_take", {17'b0, pc}, 32'd20);
        // D=1, D;JEQ not taken
        run(16'hEFD0);
        run(16'hE302);
        check("jeq_not", {17'b0, pc}, 32'd22);
        // D=-1, D;JGT not taken (ng)
        run(16'hEE90);
        fetch(16'hE301);
        check("jgt_ng", {31'b0, alu_ng}, 32'd1);
        tick();
        check("jgt_not", {17'b0, pc}, 32'd24);

        // A=30, A=A+1;JMP -> jump uses old A
        run(16'h001E);
        run(16'hEDE7);
        check("ajmp_a", {17'b0, addressM}, 32'd31);
        check("ajmp_pc", {17'b0, pc}, 32'd30);

        // Jump to 0x7FFF, then @0 wraps PC
        run(16'h7FFF);
        run(16'hEA87);
        check("wrap_pre", {17'b0, pc}, 32'h7FFF);
        run(16'h0000);
        check("wrap_pc", {17'b0, pc}, 32'd0);
        check("wrap_a", {17'b0, addressM}, 32'd0);

        // @100, M=D with hold for 3 cycles in EXECUTE (D is 0xFFFF)
        run(16'h0064);
        fetch(16'hE308);
        hold = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("hold_wr", {31'b0, writeM}, 32'd0);
            check("hold_state", {31'b0, state_exec}, 32'd1);
            check("hold_pc", {17'b0, pc}, 32'd1);
            tick();
        end
        hold = 1'b0;
        #1;
        check("resume_wr", {31'b0, writeM}, 32'd1);
        check("resume_out", {16'b0, outM}, 32'hFFFF);
        check("resume_addr", {17'b0, addressM}, 32'd100);
        tick();
        check("resume_pc", {17'b0, pc}, 32'd2);

        // Reset (with hold, reset wins) during EXECUTE of M=D
        fetch(16'hE308);
        reset = 1'b1;
        hold  = 1'b1;
        #1;
        check("rstx_wr", {31'b0, writeM}, 32'd0);
        tick();
        reset = 1'b0;
        hold  = 1'b0;
        #1;
        check("rstx_pc", {17'b0, pc}, 32'd0);
        check("rstx_state", {31'b0, state_exec}, 32'd0);
        check("rstx_a", {17'b0, addressM}, 32'd0);
        check("rstx_d", {16'b0, alu_x}, 32'd0);
        check("total_wr", wr_cnt, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
